ica_pass_sequencer: RTL and testbench

- Sequences one complete FastICA run over the shared sample memory: whitening, storing whitened samples, then repeated FastICA passes over the stored samples.
- Uses clock-enable strobes instead of gated clocks, so the whitening, memory and FastICA blocks all run on the single system clock.
- Sits between the top-level go input and the whitening, sample RAM and FastICA blocks.
- Owns the RAM address and the read/write select, and ends the run on convergence, iteration limit or timeout.

---
 rtl/ica_pkg.sv | 25 ++
 rtl/busy_edge_watch.sv | 32 +++
 rtl/ica_pass_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_ica_pass_sequencer.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ica_pkg.sv
// Shared types and constants for the FastICA run sequencer and its helpers.
package ica_pkg;

  localparam int ADDR_W    = 14;
  localparam int DATA_W    = 26;
  localparam int N_SAMPLES = 16384;

  typedef enum logic [3:0] {
    IDLE,
    WHT_START,
    WHT_WAIT,
    WR_REQ,
    WR_STORE,
    ICA_START,
    ICA_READ,
    ICA_WAIT,
    DONE
  } seq_state_e;

  // Pass counter increment that sticks at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/busy_edge_watch.sv
// Watches one busy handshake: flags its rise-then-fall and a wait that ran too long.
module busy_edge_watch #(
  parameter int TIMEOUT = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic active,
  input  logic busy_in,
  output logic fell_pulse,
  output logic timeout_pulse
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic             seen_rise;
  logic [CNT_W-1:0] wait_cnt;

  // Leaving the wait state clears everything, so each entry starts a fresh wait.
  always_ff @(posedge clk) begin
    if (!rst_n || !active) begin
      seen_rise <= 1'b0;
      wait_cnt  <= '0;
    end else begin
      if (busy_in) seen_rise <= 1'b1;
      if (!timeout_pulse) wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  assign fell_pulse    = active && seen_rise && !busy_in;
  assign timeout_pulse = active && (wait_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/ica_pass_sequencer.sv
// Sequences whitening, sample storage and repeated FastICA passes over the
// shared sample RAM, using clock enables on the single system clock.
module ica_pass_sequencer #(
  parameter int N_SAMPLES    = ica_pkg::N_SAMPLES,
  parameter int ADDR_W       = ica_pkg::ADDR_W,
  parameter int MAX_ITER     = 64,
  parameter int BUSY_TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              go,
  input  logic              whitening_busy,
  input  logic              fastica_busy,
  input  logic              converged,
  output logic              go_whitening,
  output logic              en_whitening,
  output logic              new_one,
  output logic              en_mem,
  output logic              rw,
  output logic [ADDR_W-1:0] addr,
  output logic              go_fastica,
  output logic              en_fastica,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [7:0]        iter_count
);

  import ica_pkg::*;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_SAMPLES - 1);

  seq_state_e state;
  logic       go_q;
  logic       draining;
  logic       wht_active, ica_active;
  logic       wht_fell, wht_timeout;
  logic       ica_fell, ica_timeout;
  logic [7:0] iter_next;

  assign wht_active = (state == WHT_WAIT);
  assign ica_active = (state == ICA_WAIT);
  assign iter_next  = sat_inc8(iter_count);

  busy_edge_watch #(.TIMEOUT(BUSY_TIMEOUT)) u_wht_watch (
    .clk           (clk),
    .rst_n         (rst_n),
    .active        (wht_active),
    .busy_in       (whitening_busy),
    .fell_pulse    (wht_fell),
    .timeout_pulse (wht_timeout)
  );

  busy_edge_watch #(.TIMEOUT(BUSY_TIMEOUT)) u_ica_watch (
    .clk           (clk),
    .rst_n         (rst_n),
    .active        (ica_active),
    .busy_in       (fastica_busy),
    .fell_pulse    (ica_fell),
    .timeout_pulse (ica_timeout)
  );

  // Outputs are registered alongside the state, so each one is set on the
  // transition into the state that owns it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      go_q         <= 1'b0;
      draining     <= 1'b0;
      go_whitening <= 1'b0;
      en_whitening <= 1'b0;
      new_one      <= 1'b0;
      en_mem       <= 1'b0;
      rw           <= 1'b0;
      addr         <= '0;
      go_fastica   <= 1'b0;
      en_fastica   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      iter_count   <= '0;
    end else begin
      go_q         <= go;
      go_whitening <= 1'b0;
      new_one      <= 1'b0;
      go_fastica   <= 1'b0;
      done         <= 1'b0;
      // RAM read data appears one cycle after the read strobe.
      en_fastica   <= en_mem && !rw;

      case (state)
        IDLE: begin
          if (go && !go_q) begin
            state        <= WHT_START;
            busy         <= 1'b1;
            error        <= 1'b0;
            iter_count   <= '0;
            go_whitening <= 1'b1;
            en_whitening <= 1'b1;
          end
        end

        WHT_START: state <= WHT_WAIT;

        WHT_WAIT: begin
          if (wht_fell) begin
            addr    <= '0;
            state   <= WR_REQ;
            new_one <= 1'b1;
          end else if (wht_timeout) begin
            error        <= 1'b1;
            en_whitening <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
            state        <= DONE;
          end
        end

        WR_REQ: begin
          state        <= WR_STORE;
          en_whitening <= 1'b0;
          en_mem       <= 1'b1;
          rw           <= 1'b1;
        end

        WR_STORE: begin
          en_mem <= 1'b0;
          rw     <= 1'b0;
          if (addr == LAST_ADDR) begin
            addr       <= '0;
            state      <= ICA_START;
            go_fastica <= 1'b1;
          end else begin
            addr         <= addr + ADDR_W'(1);
            state        <= WR_REQ;
            new_one      <= 1'b1;
            en_whitening <= 1'b1;
          end
        end

        ICA_START: begin
          state  <= ICA_READ;
          en_mem <= 1'b1;
        end

        // The extra drain cycle lets the last sample reach FastICA before waiting.
        ICA_READ: begin
          if (draining) begin
            draining <= 1'b0;
            state    <= ICA_WAIT;
          end else if (addr == LAST_ADDR) begin
            en_mem   <= 1'b0;
            draining <= 1'b1;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end

        ICA_WAIT: begin
          if (ica_fell) begin
            iter_count <= iter_next;
            if (converged || (32'(iter_next) == MAX_ITER)) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              addr       <= '0;
              state      <= ICA_START;
              go_fastica <= 1'b1;
            end
          end else if (ica_timeout) begin
            error <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end

        DONE: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ica_pass_sequencer.sv
// Table-driven and randomized runs of ica_pass_sequencer against an event-level model.
module tb_ica_pass_sequencer;

  localparam int SMALL_N  = 4;
  localparam int SMALL_TO = 10;
  localparam int BIG_N    = 16384;

  typedef struct {
    int         w_gap, w_dur, f_gap, f_dur;
    logic [7:0] conv_mask;
    int         go_hold, extra_go;
    bit         big;
    int         rst_at_write;
    int         exp_passes, exp_writes, exp_iter, exp_error;
  } run_t;

  logic clk = 1'b0;
  logic rst_n, go_s, go_b, whitening_busy, fastica_busy, converged;
  bit   sel_big;

  logic s_go_whitening, s_en_whitening, s_new_one, s_en_mem, s_rw, s_go_fastica;
  logic s_en_fastica, s_busy, s_done, s_error;
  logic [13:0] s_addr;
  logic [7:0]  s_iter;
  logic b_go_whitening, b_en_whitening, b_new_one, b_en_mem, b_rw, b_go_fastica;
  logic b_en_fastica, b_busy, b_done, b_error;
  logic [13:0] b_addr;
  logic [7:0]  b_iter;

  logic m_go_whitening, m_new_one, m_en_mem, m_rw, m_go_fastica, m_en_fastica;
  logic m_busy, m_done, m_error;
  logic [13:0] m_addr;
  logic [7:0]  m_iter;
  logic [31:0] s_outs;

  int vectors = 0;
  int miscompares = 0;

  int stat_go_wht, stat_new_one, stat_writes, stat_wr_order, stat_wr_nopre, stat_wr_space;
  int stat_reads, stat_rd_order, stat_fast, stat_fast_align, stat_go_fast, stat_gof_bad;
  int stat_done, stat_busy_gap, stat_rw_stray, stat_range, stat_t_gw, stat_t_err;
  int stat_iter, stat_err, stat_gw_addr;
  logic [31:0] stat_rst_outs;

  always #5 clk = ~clk;

  ica_pass_sequencer #(.N_SAMPLES(SMALL_N), .ADDR_W(14), .MAX_ITER(3), .BUSY_TIMEOUT(SMALL_TO)) dut (
    .clk(clk), .rst_n(rst_n), .go(go_s), .whitening_busy(whitening_busy),
    .fastica_busy(fastica_busy), .converged(converged),
    .go_whitening(s_go_whitening), .en_whitening(s_en_whitening), .new_one(s_new_one),
    .en_mem(s_en_mem), .rw(s_rw), .addr(s_addr), .go_fastica(s_go_fastica),
    .en_fastica(s_en_fastica), .busy(s_busy), .done(s_done), .error(s_error),
    .iter_count(s_iter)
  );

  ica_pass_sequencer #(.N_SAMPLES(BIG_N), .ADDR_W(14), .MAX_ITER(1), .BUSY_TIMEOUT(65535)) dut_big (
    .clk(clk), .rst_n(rst_n), .go(go_b), .whitening_busy(whitening_busy),
    .fastica_busy(fastica_busy), .converged(converged),
    .go_whitening(b_go_whitening), .en_whitening(b_en_whitening), .new_one(b_new_one),
    .en_mem(b_en_mem), .rw(b_rw), .addr(b_addr), .go_fastica(b_go_fastica),
    .en_fastica(b_en_fastica), .busy(b_busy), .done(b_done), .error(b_error),
    .iter_count(b_iter)
  );

  assign m_go_whitening = sel_big ? b_go_whitening : s_go_whitening;
  assign m_new_one      = sel_big ? b_new_one      : s_new_one;
  assign m_en_mem       = sel_big ? b_en_mem       : s_en_mem;
  assign m_rw           = sel_big ? b_rw           : s_rw;
  assign m_go_fastica   = sel_big ? b_go_fastica   : s_go_fastica;
  assign m_en_fastica   = sel_big ? b_en_fastica   : s_en_fastica;
  assign m_busy         = sel_big ? b_busy         : s_busy;
  assign m_done         = sel_big ? b_done         : s_done;
  assign m_error        = sel_big ? b_error        : s_error;
  assign m_addr         = sel_big ? b_addr         : s_addr;
  assign m_iter         = sel_big ? b_iter         : s_iter;
  assign s_outs = {s_go_whitening, s_en_whitening, s_new_one, s_en_mem, s_rw, s_addr,
                   s_go_fastica, s_en_fastica, s_busy, s_done, s_error, s_iter};

  task automatic checkValue(input string name, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic run_t mkRun(input int wg, wd, fg, fd, input logic [7:0] mask,
                                 input int hold, extra, input bit big, input int rst,
                                 input int ep, ew, ei, ee);
    run_t r;
    r.w_gap = wg; r.w_dur = wd; r.f_gap = fg; r.f_dur = fd; r.conv_mask = mask;
    r.go_hold = hold; r.extra_go = extra; r.big = big; r.rst_at_write = rst;
    r.exp_passes = ep; r.exp_writes = ew; r.exp_iter = ei; r.exp_error = ee;
    return r;
  endfunction

  // Reference model: outcome of a run from the handshake behaviour alone.
  function automatic run_t fillExpect(input run_t r);
    int mi;
    mi = r.big ? 1 : 3;
    r.exp_passes = 0; r.exp_writes = 0; r.exp_iter = 0; r.exp_error = 0;
    if (r.w_dur == 0) begin
      r.exp_error = 1;
      return r;
    end
    r.exp_writes = r.big ? BIG_N : SMALL_N;
    for (int p = 1; p <= mi; p++) begin
      r.exp_passes = p;
      if (r.f_dur == 0) begin
        r.exp_error = 1;
        break;
      end
      r.exp_iter = p;
      if (r.conv_mask[p-1]) break;
    end
    return r;
  endfunction

  task automatic applyStimulus(input run_t r);
    int n, budget, post, w_rise, w_left, f_rise, f_left, pass, last_wr;
    bit done_seen, prev_read, prev_new, prev_fast, w_arm, f_arm, rst_pending, wr_now, rd_now, gv;
    n = r.big ? BIG_N : SMALL_N;
    budget = 2 * n + 4 * (n + 40) + 200;
    {stat_go_wht, stat_new_one, stat_writes, stat_wr_order, stat_wr_nopre, stat_wr_space} = '0;
    {stat_reads, stat_rd_order, stat_fast, stat_fast_align, stat_go_fast, stat_gof_bad} = '0;
    {stat_done, stat_busy_gap, stat_rw_stray, stat_range, stat_iter, stat_err} = '0;
    stat_t_gw = -1; stat_t_err = -1; stat_gw_addr = -1; stat_rst_outs = '1;
    post = 0; pass = 0; last_wr = -10; w_rise = 0; w_left = 0; f_rise = 0; f_left = 0;
    {done_seen, prev_read, prev_new, prev_fast, w_arm, f_arm, rst_pending} = '0;
    sel_big = r.big;
    whitening_busy = 1'b0; fastica_busy = 1'b0; converged = 1'b0;
    if (r.big) go_b = 1'b1; else go_s = 1'b1;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clk);
      if (rst_pending) begin
        stat_rst_outs = s_outs;
        rst_n = 1'b1;
        break;
      end
      wr_now = m_en_mem && m_rw;
      rd_now = m_en_mem && !m_rw;
      if (m_go_whitening) begin
        stat_go_wht++;
        if (stat_t_gw < 0) begin
          stat_t_gw = cyc;
          stat_gw_addr = int'(m_addr);
        end
      end
      if (m_new_one) stat_new_one++;
      if (wr_now) begin
        if (!prev_new) stat_wr_nopre++;
        if (int'(m_addr) != stat_writes) stat_wr_order++;
        if (stat_writes > 0 && cyc - last_wr != 2) stat_wr_space++;
        last_wr = cyc;
        stat_writes++;
      end
      if (rd_now) begin
        if (int'(m_addr) != stat_reads % n) stat_rd_order++;
        stat_reads++;
      end
      if (m_en_fastica) stat_fast++;
      if (m_en_fastica != prev_read) stat_fast_align++;
      if (m_go_fastica) begin
        stat_go_fast++;
        if (m_addr != 14'd0 || m_rw) stat_gof_bad++;
      end
      if (m_rw && !m_en_mem) stat_rw_stray++;
      if (int'(m_addr) >= n) stat_range++;
      if (m_error && stat_t_err < 0) stat_t_err = cyc;
      if (m_done) begin
        stat_done++;
        if (m_busy) stat_busy_gap++;
        done_seen = 1'b1;
        stat_iter = int'(m_iter);
        stat_err = int'(m_error);
      end else if (m_busy == done_seen) begin
        stat_busy_gap++;
      end

      if (m_go_whitening && r.w_dur > 0 && !w_arm) begin
        w_arm = 1'b1; w_rise = r.w_gap; w_left = r.w_dur;
      end else if (w_arm) begin
        if (w_rise > 0) w_rise--;
        else if (w_left > 0) begin whitening_busy = 1'b1; w_left--; end
        else begin whitening_busy = 1'b0; w_arm = 1'b0; end
      end
      if (m_go_fastica) begin
        pass++;
        converged = 1'b0;
      end
      if (prev_fast && !m_en_fastica && r.f_dur > 0) begin
        f_arm = 1'b1; f_rise = r.f_gap; f_left = r.f_dur;
        converged = (pass >= 1 && pass <= 8) ? r.conv_mask[pass-1] : 1'b0;
      end else if (f_arm) begin
        if (f_rise > 0) f_rise--;
        else if (f_left > 0) begin fastica_busy = 1'b1; f_left--; end
        else begin fastica_busy = 1'b0; f_arm = 1'b0; end
      end

      gv = (cyc < r.go_hold - 1) || (cyc == r.extra_go);
      if (r.big) go_b = gv; else go_s = gv;
      if (r.rst_at_write > 0 && wr_now && stat_writes == r.rst_at_write) begin
        rst_n = 1'b0;
        rst_pending = 1'b1;
      end
      prev_read = rd_now;
      prev_new  = m_new_one;
      prev_fast = m_en_fastica;
      if (done_seen) begin
        post++;
        if (post >= 3) break;
      end
    end
    go_s = 1'b0; go_b = 1'b0;
    whitening_busy = 1'b0; fastica_busy = 1'b0; converged = 1'b0;
    @(negedge clk);
  endtask

  task automatic checkOutput(input run_t r);
    int n;
    n = r.big ? BIG_N : SMALL_N;
    checkValue("go_whitening_pulses", stat_go_wht, 1);
    checkValue("new_one_pulses", stat_new_one, r.exp_writes);
    checkValue("write_count", stat_writes, r.exp_writes);
    checkValue("write_addr_order", stat_wr_order, 0);
    checkValue("write_without_new_one", stat_wr_nopre, 0);
    checkValue("write_spacing", stat_wr_space, 0);
    checkValue("read_count", stat_reads, r.exp_passes * n);
    checkValue("read_addr_order", stat_rd_order, 0);
    checkValue("en_fastica_count", stat_fast, r.exp_passes * n);
    checkValue("en_fastica_alignment", stat_fast_align, 0);
    checkValue("go_fastica_pulses", stat_go_fast, r.exp_passes);
    checkValue("go_fastica_addr_rw", stat_gof_bad, 0);
    checkValue("done_pulses", stat_done, 1);
    checkValue("iter_count", stat_iter, r.exp_iter);
    checkValue("error_flag", stat_err, r.exp_error);
    checkValue("busy_continuity", stat_busy_gap, 0);
    checkValue("rw_outside_write", stat_rw_stray, 0);
    checkValue("addr_range", stat_range, 0);
    if (r.w_dur == 0)
      checkValue("whitening_timeout_latency",
                 (stat_t_err - stat_t_gw >= SMALL_TO && stat_t_err - stat_t_gw <= SMALL_TO + 1), 1);
  endtask

  initial begin
    run_t tbl[6];
    run_t r;
    int idle_bad;
    rst_n = 1'b0; go_s = 1'b0; go_b = 1'b0; sel_big = 1'b0;
    whitening_busy = 1'b0; fastica_busy = 1'b0; converged = 1'b0;
    tbl[0] = mkRun(0, 5, 1, 3, 8'b001, 1, -1, 0, 0, 1, 4, 1, 0);
    tbl[1] = mkRun(0, 5, 1, 3, 8'b000, 1, -1, 0, 0, 3, 4, 3, 0);
    tbl[2] = mkRun(1, 3, 0, 2, 8'b010, 1, -1, 0, 0, 2, 4, 2, 0);
    tbl[3] = mkRun(0, 0, 1, 3, 8'b001, 1, -1, 0, 0, 0, 0, 0, 1);
    tbl[4] = mkRun(0, 5, 0, 0, 8'b000, 1, -1, 0, 0, 1, 4, 0, 1);
    tbl[5] = mkRun(0, 5, 1, 3, 8'b000, 20, 30, 0, 0, 3, 4, 3, 0);

    repeat (3) @(negedge clk);
    checkValue("reset_outputs", s_outs, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      applyStimulus(tbl[i]);
      checkOutput(tbl[i]);
    end

    // Reset during the second write, then confirm idle and a clean restart.
    r = mkRun(0, 5, 1, 3, 8'b001, 1, -1, 0, 2, 0, 0, 0, 0);
    applyStimulus(r);
    checkValue("writes_before_reset", stat_writes, 2);
    checkValue("outputs_after_midrun_reset", stat_rst_outs, 0);
    idle_bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (s_outs != 32'd0) idle_bad++;
    end
    checkValue("idle_after_reset", idle_bad, 0);
    r = mkRun(0, 5, 1, 3, 8'b001, 1, -1, 0, 0, 1, 4, 1, 0);
    applyStimulus(r);
    checkValue("restart_addr_at_go_whitening", stat_gw_addr, 0);
    checkOutput(r);

    for (int i = 0; i < 6; i++) begin
      r = mkRun($urandom_range(2, 0), $urandom_range(4, 1), $urandom_range(2, 0),
                $urandom_range(4, 1), 8'($urandom_range(7, 0)), $urandom_range(3, 1),
                ($urandom_range(1, 0) == 1) ? $urandom_range(18, 5) : -1, 0, 0, 0, 0, 0, 0);
      r = fillExpect(r);
      applyStimulus(r);
      checkOutput(r);
    end

    r = fillExpect(mkRun(0, 5, 1, 3, 8'b000, 1, -1, 1, 0, 0, 0, 0, 0));
    applyStimulus(r);
    checkOutput(r);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
